// File: rtl/dcache_refill_pkg.sv
// Shared types for the data-cache refill responder: FSM states, queued request record,
// and helpers for beats-per-line and beat-counter width.
package dcache_refill_pkg;

  localparam int unsigned ReqAddrWidth = 64;
  localparam int unsigned ReqTidWidth  = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    ERR
  } state_e;

  typedef struct packed {
    logic [ReqAddrWidth-1:0] addr;
    logic [ReqTidWidth-1:0]  tid;
  } req_t;

  function automatic int unsigned beats_per_line(input int unsigned line_w,
                                                 input int unsigned data_w);
    return line_w / data_w;
  endfunction

  function automatic int unsigned beat_cnt_width(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO (power-of-2 depth): optional fall-through, 0/1-cycle read latency.
// Pushes while full and pops while empty are dropped; the producer must honour full_o.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic,
  localparam int unsigned AddrDepth   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  logic [AddrDepth-1:0] r_rd_ptr;
  logic [AddrDepth-1:0] r_wr_ptr;
  logic [AddrDepth:0]   r_count;
  dtype                 r_mem [DEPTH];

  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_is_empty;

  assign w_is_empty = (r_count == '0);
  assign full_o     = (r_count == (AddrDepth + 1)'(DEPTH));
  assign empty_o    = w_is_empty && !(FALL_THROUGH && push_i);
  assign data_o     = (FALL_THROUGH && w_is_empty) ? data_i : r_mem[r_rd_ptr];

  // A fall-through push consumed in the same cycle never enters storage.
  assign w_bypass = FALL_THROUGH && w_is_empty && push_i && pop_i;
  assign w_push   = push_i && !full_o && !w_bypass;
  assign w_pop    = pop_i && !w_is_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AddrDepth'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AddrDepth'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AddrDepth + 1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AddrDepth + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/dcache_refill_responder.sv
// Refill responder: queues line reads, fetches each beat from memory and returns beats in request order.
// First beat 4 cycles after accept on a zero-wait memory; req_ready_o drops only while the queue is full.
module dcache_refill_responder
  import dcache_refill_pkg::*;
#(
  parameter int unsigned          AddrWidth    = 64,
  parameter int unsigned          DataWidth    = 64,
  parameter int unsigned          LineWidth    = 128,
  parameter int unsigned          TidWidth     = 2,
  parameter int unsigned          ReqFifoDepth = 4,
  parameter logic [AddrWidth-1:0] RegionBase   = AddrWidth'(64'h8000_0000),
  parameter logic [AddrWidth-1:0] RegionLength = AddrWidth'(64'h4000_0000)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [TidWidth-1:0]  req_tid_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic [TidWidth-1:0]  rsp_tid_o,
  output logic                 rsp_last_o,
  output logic                 rsp_error_o
);

  localparam int unsigned          NB        = beats_per_line(LineWidth, DataWidth);
  localparam int unsigned          CntWidth  = beat_cnt_width(NB);
  localparam logic [CntWidth-1:0]  LastBeat  = CntWidth'(NB - 1);
  localparam logic [AddrWidth-1:0] BeatBytes = AddrWidth'(DataWidth / 8);
  localparam logic [AddrWidth-1:0] LineMask  = ~(AddrWidth'(LineWidth / 8) - AddrWidth'(1));
  // One extra bit so a region ending at the top of the address space does not wrap.
  localparam logic [AddrWidth:0]   RegionEnd = {1'b0, RegionBase} + {1'b0, RegionLength};

  state_e r_state;
  state_e w_state_d;

  logic [AddrWidth-1:0] r_line_base;
  logic [TidWidth-1:0]  r_tid;
  logic [CntWidth-1:0]  r_beat;
  logic [DataWidth-1:0] r_beat_data;

  logic                 w_rst_n;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_push;
  req_t                 w_push_req;
  req_t                 w_head;
  logic [AddrWidth-1:0] w_head_base;
  logic                 w_head_in_region;
  logic                 w_last_beat;
  logic                 w_load;
  logic                 w_capture;
  logic                 w_beat_inc;

  assign w_rst_n          = !rst_i;
  assign req_ready_o      = !w_fifo_full;
  assign w_push           = req_valid_i && req_ready_o;
  assign w_push_req.addr  = ReqAddrWidth'(req_addr_i);
  assign w_push_req.tid   = ReqTidWidth'(req_tid_i);

  fifo_v3 #(
    .FALL_THROUGH(1'b0),
    .DEPTH       (ReqFifoDepth),
    .dtype       (req_t)
  ) u_req_fifo (
    .clk_i  (clk_i),
    .rst_ni (w_rst_n),
    .flush_i(1'b0),
    .full_o (w_fifo_full),
    .empty_o(w_fifo_empty),
    .data_i (w_push_req),
    .push_i (w_push),
    .data_o (w_head),
    .pop_i  (w_load)
  );

  assign w_head_base      = AddrWidth'(w_head.addr) & LineMask;
  assign w_head_in_region = (w_head_base >= RegionBase) && ({1'b0, w_head_base} < RegionEnd);
  assign w_last_beat      = (r_beat == LastBeat);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d   = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_beat_inc  = 1'b0;
    mem_req_o   = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_error_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_load    = 1'b1;
          w_state_d = w_head_in_region ? FETCH : ERR;
        end
      end
      FETCH: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) w_state_d = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          w_capture = 1'b1;
          w_state_d = SEND;
        end
      end
      SEND: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          if (w_last_beat) begin
            w_state_d = IDLE;
          end else begin
            w_beat_inc = 1'b1;
            w_state_d  = FETCH;
          end
        end
      end
      ERR: begin
        rsp_valid_o = 1'b1;
        rsp_error_o = 1'b1;
        if (rsp_ready_i) begin
          if (w_last_beat) w_state_d = IDLE;
          else             w_beat_inc = 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_line_base <= '0;
      r_tid       <= '0;
      r_beat      <= '0;
      r_beat_data <= '0;
    end else begin
      if (w_load) begin
        r_line_base <= w_head_base;
        r_tid       <= TidWidth'(w_head.tid);
        r_beat      <= '0;
      end else if (w_beat_inc) begin
        r_beat <= r_beat + CntWidth'(1);
      end
      if (w_capture) r_beat_data <= mem_rdata_i;
    end
  end

  assign mem_addr_o = r_line_base + AddrWidth'(r_beat) * BeatBytes;
  assign rsp_data_o = (r_state == SEND) ? r_beat_data : '0;
  assign rsp_tid_o  = r_tid;
  assign rsp_last_o = rsp_valid_o && w_last_beat;

endmodule

// File: tb/tb_dcache_refill_responder.sv
// Bench for dcache_refill_responder: latency table, hand-written corner sequences and a
// randomized phase scored against a queue-based line/beat model.
module tb_dcache_refill_responder;

  localparam int unsigned NB   = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] LEN  = 64'h4000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic [1:0]  req_tid_i;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [63:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_data_o;
  logic [1:0]  rsp_tid_o;
  logic        rsp_last_o;
  logic        rsp_error_o;

  dcache_refill_responder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_tid_i   (req_tid_i),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_addr_o  (mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_tid_o   (rsp_tid_o),
    .rsp_last_o  (rsp_last_o),
    .rsp_error_o (rsp_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  tid;
    logic        last;
    logic        err;
  } beat_t;

  typedef struct {
    logic [63:0] addr;
    logic [1:0]  tid;
    int          lat1;
    int          lat2;
    logic        exp_mreq;
  } vec_t;

  beat_t       exp_q[$];
  logic [63:0] addr_q[$];
  int          tests = 0;
  int          fails = 0;

  int   gnt_delay = 0;
  int   rv_delay  = 0;
  bit   rnd_mem   = 1'b0;
  int   rdy_mode  = 0;
  logic rdy_fixed = 1'b1;

  function automatic logic [63:0] mdata(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a line is NB beats; in-region lines read memory, others return zero error beats.
  task automatic model_push(input logic [63:0] addr, input logic [1:0] tid);
    logic [63:0] line;
    logic        inreg;
    beat_t       b;
    line  = addr & ~64'hF;
    inreg = (line >= BASE) && (line < BASE + LEN);
    for (int i = 0; i < NB; i++) begin
      b.data = inreg ? mdata(line + 64'(i * 8)) : 64'd0;
      b.tid  = tid;
      b.last = (i == NB - 1);
      b.err  = !inreg;
      exp_q.push_back(b);
      if (inreg) addr_q.push_back(line + 64'(i * 8));
    end
  endtask

  // Backing memory: grant after a (possibly random) delay, one rvalid per grant.
  initial begin
    bit          pend;
    int          pend_cnt;
    logic [63:0] pend_addr;
    int          wait_cnt;
    int          tgt;
    pend = 1'b0; pend_cnt = 0; pend_addr = '0; wait_cnt = 0; tgt = 0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = {$urandom, $urandom};
      if (pend) begin
        if (pend_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = mdata(pend_addr);
          pend         = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      mem_gnt_i = 1'b0;
      if (mem_req_o && !pend) begin
        if (wait_cnt == 0) tgt = rnd_mem ? int'($urandom_range(0, 3)) : gnt_delay;
        if (wait_cnt >= tgt) begin
          mem_gnt_i = 1'b1;
          pend      = 1'b1;
          pend_cnt  = rnd_mem ? int'($urandom_range(0, 2)) : rv_delay;
          pend_addr = mem_addr_o;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Response-ready driver: 0 = fixed level, 1 = toggle every cycle, 2 = random.
  initial begin
    rsp_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #2;
      case (rdy_mode)
        1:       rsp_ready_i = ~rsp_ready_i;
        2:       rsp_ready_i = 1'($urandom_range(0, 1));
        default: rsp_ready_i = rdy_fixed;
      endcase
    end
  end

  // Monitor: scoreboard on handshakes, plus stability of stalled outputs.
  initial begin
    logic        p_rv, p_rr, p_mq, p_mg;
    logic [63:0] p_data, p_maddr;
    logic [4:0]  p_ctl;
    beat_t       e;
    logic [63:0] ea;
    p_rv = 0; p_rr = 0; p_mq = 0; p_mg = 0; p_data = '0; p_maddr = '0; p_ctl = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        p_rv = 0; p_mq = 0;
      end else begin
        if (req_valid_i && req_ready_o) model_push(req_addr_i, req_tid_i);
        if (mem_req_o && mem_gnt_i) begin
          if (addr_q.size() == 0) chk("unexpected_mem_req", 64'(mem_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            ea = addr_q.pop_front();
            chk("mem_addr", mem_addr_o, ea);
          end
        end
        if (rsp_valid_o && rsp_ready_i) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", 64'(rsp_tid_o), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("rsp_data", rsp_data_o, e.data);
            chk("rsp_tid", 64'(rsp_tid_o), 64'(e.tid));
            chk("rsp_last", 64'(rsp_last_o), 64'(e.last));
            chk("rsp_error", 64'(rsp_error_o), 64'(e.err));
          end
        end
        if (p_rv && !p_rr) begin
          chk("rsp_hold_ctl", 64'({rsp_valid_o, rsp_last_o, rsp_error_o, rsp_tid_o}), 64'(p_ctl));
          chk("rsp_hold_data", rsp_data_o, p_data);
        end
        if (p_mq && !p_mg) begin
          chk("mem_hold_req", 64'(mem_req_o), 64'd1);
          chk("mem_hold_addr", mem_addr_o, p_maddr);
        end
        p_rv = rsp_valid_o; p_rr = rsp_ready_i; p_data = rsp_data_o;
        p_ctl = {rsp_valid_o, rsp_last_o, rsp_error_o, rsp_tid_o};
        p_mq = mem_req_o; p_mg = mem_gnt_i; p_maddr = mem_addr_o;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_req"}, 64'(mem_req_o), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, "_rsp_last"}, 64'(rsp_last_o), 64'd0);
    chk({tag, "_rsp_error"}, 64'(rsp_error_o), 64'd0);
    chk({tag, "_rsp_data"}, rsp_data_o, 64'd0);
    chk({tag, "_rsp_tid"}, 64'(rsp_tid_o), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr_o, 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
  endtask

  // Present a request from the next cycle on and hold it until accepted.
  task automatic send(input logic [63:0] a, input logic [1:0] t);
    bit acc;
    acc = 0;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b1; req_addr_i = a; req_tid_i = t;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_i);
      if (req_ready_o) begin acc = 1; break; end
      @(posedge clk_i);
      #1;
    end
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic req_idle();
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (k < 3000 && (exp_q.size() != 0 || rsp_valid_o)) begin
      @(negedge clk_i);
      k++;
    end
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   first, last, acc;
    bit   saw_mreq, saw_rsp, got_gnt;

    vecs[0] = '{64'h0000_0000_8000_0048, 2'd1, 4, 3, 1'b1};
    vecs[1] = '{64'h0000_0000_0000_1000, 2'd2, 2, 1, 1'b0};
    vecs[2] = '{64'h0000_0000_8000_0000, 2'd0, 4, 3, 1'b1};
    vecs[3] = '{64'h0000_0000_7FFF_FFFF, 2'd3, 2, 1, 1'b0};
    vecs[4] = '{64'h0000_0000_BFFF_FFFF, 2'd1, 4, 3, 1'b1};
    vecs[5] = '{64'h0000_0000_C000_0000, 2'd2, 2, 1, 1'b0};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 2, 1, 1'b0};

    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_tid_i = '0;
    repeat (3) @(negedge clk_i);
    check_reset_vals("in_reset");
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_reset_vals("after_reset");

    // Latency table: single requests into an idle responder, zero-wait memory, always ready.
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].addr, vecs[v].tid);
      req_idle();
      first = 0; last = 0; saw_mreq = 0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk_i);
        if (mem_req_o) saw_mreq = 1;
        if (rsp_valid_o && first == 0) first = k;
        if (rsp_valid_o && rsp_last_o) begin last = k; break; end
      end
      chk($sformatf("vec%0d_first_beat_lat", v), 64'(first), 64'(vecs[v].lat1));
      chk($sformatf("vec%0d_last_beat_gap", v), 64'(last - first), 64'(vecs[v].lat2));
      chk($sformatf("vec%0d_mem_req_seen", v), 64'(saw_mreq), 64'(vecs[v].exp_mreq));
      drain($sformatf("vec%0d", v));
    end

    // Back-to-back tids 0,1,2.
    send(64'h8000_2000, 2'd0);
    send(64'h0000_0040, 2'd1);
    send(64'h8000_3008, 2'd2);
    req_idle();
    drain("b2b");

    // Response side stalled: five requests fit (queue of four plus one in service).
    @(posedge clk_i);
    #1;
    rdy_fixed = 1'b0;
    req_valid_i = 1'b1; req_addr_i = 64'h8000_1000; req_tid_i = 2'd0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (req_valid_i && req_ready_o) acc++;
      @(posedge clk_i);
      #1;
      if (acc < 5) begin
        req_addr_i = 64'h8000_1000 + 64'(acc * 64);
        req_tid_i  = 2'(acc);
      end else begin
        req_valid_i = 1'b0;
      end
    end
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_ready_low", 64'(req_ready_o), 64'd0);
    rdy_fixed = 1'b1;
    drain("bp");
    chk("bp_ready_back", 64'(req_ready_o), 64'd1);

    // Slow grants and toggling ready.
    gnt_delay = 3;
    rdy_fixed = 1'b0;
    send(64'h8000_4010, 2'd3);
    send(64'h1000_0000, 2'd2);
    send(64'h8000_5020, 2'd1);
    req_idle();
    rdy_mode = 1;
    drain("stall");
    rdy_mode = 0;
    rdy_fixed = 1'b1;
    gnt_delay = 0;
    repeat (2) @(negedge clk_i);

    // Reset during WAIT of beat 0 with a late read return.
    rv_delay = 4;
    send(64'h8000_0100, 2'd3);
    req_idle();
    got_gnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (mem_req_o && mem_gnt_i) begin got_gnt = 1; break; end
    end
    chk("rst_test_granted", 64'(got_gnt), 64'd1);
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check_reset_vals("mid_line_reset");
    exp_q.delete();
    addr_q.delete();
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    saw_rsp = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (rsp_valid_o) saw_rsp = 1;
    end
    chk("no_rsp_after_reset", 64'(saw_rsp), 64'd0);
    rv_delay = 0;
    send(64'h8000_0200, 2'd2);
    req_idle();
    drain("post_reset");

    // Randomized traffic.
    rnd_mem  = 1'b1;
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) req_idle();
      if ($urandom_range(0, 3) == 0) send({$urandom, $urandom}, 2'($urandom));
      else send(BASE + 64'($urandom_range(0, 32'h3FFF_FFFF)), 2'($urandom));
    end
    req_idle();
    drain("random");
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
